// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM stage and its branch condition evaluator.
package ex_mem_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_HS = 4'b0010,
    COND_LO = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/ex_mem_stage_cond_eval.sv
// Combinational B.cond evaluator: (cond, NZCV flags) -> taken. Also used by the fetch predictor.
module cond_eval
  import ex_mem_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    taken = 1'b0;
    case (cond_t'(cond))
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_HS: taken = c;
      COND_LO: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~(c & ~z);
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = ~(~z & (n == v));
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with NZCV flag register and branch resolution.
// Define EX_MEM_STATS_EN to add taken_count / flag_update_count statistics outputs.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_carry_out,
  input  logic              set_flags,
  input  logic              is_bcond,
  input  logic              is_cbz,
  input  logic [3:0]        cond,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [DATA_W-1:0] store_data_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] result_q,
  output logic [DATA_W-1:0] store_data_q,
  output logic [REG_W-1:0]  rd_q,
  output logic              reg_write_q,
  output logic              mem_read_q,
  output logic              mem_write_q,
  output logic [3:0]        flags_q,
  output logic              branch_taken_q
`ifdef EX_MEM_STATS_EN
  ,
  output logic [31:0]       taken_count,
  output logic [31:0]       flag_update_count
`endif
);

  logic bcond_true;
  logic branch_next;
  logic load_en;
  logic flag_update;
  logic [3:0] flags_next;

  // B.cond sees the pre-edge flags_q, even when the same instruction sets flags.
  cond_eval u_cond_eval (
    .cond  (cond),
    .flags (flags_q),
    .taken (bcond_true)
  );

  always_comb begin
    load_en     = ~stall & ~flush;
    branch_next = in_valid & ((is_bcond & bcond_true) | (is_cbz & alu_zero));
    flag_update = load_en & in_valid & set_flags;
    flags_next  = '0;
    flags_next[FLAG_N] = alu_negative;
    flags_next[FLAG_Z] = alu_zero;
    flags_next[FLAG_C] = alu_carry_out;
    flags_next[FLAG_V] = alu_overflow;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      result_q       <= '0;
      store_data_q   <= '0;
      rd_q           <= '0;
      reg_write_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      flags_q        <= '0;
      branch_taken_q <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        out_valid      <= 1'b0;
        result_q       <= '0;
        store_data_q   <= '0;
        rd_q           <= '0;
        reg_write_q    <= 1'b0;
        mem_read_q     <= 1'b0;
        mem_write_q    <= 1'b0;
        branch_taken_q <= 1'b0;
      end else begin
        out_valid      <= in_valid;
        result_q       <= alu_result;
        store_data_q   <= store_data_in;
        rd_q           <= rd_in;
        reg_write_q    <= reg_write_in & in_valid;
        mem_read_q     <= mem_read_in & in_valid;
        mem_write_q    <= mem_write_in & in_valid;
        branch_taken_q <= branch_next;
      end
      if (flag_update) flags_q <= flags_next;
    end
  end

`ifdef EX_MEM_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_count       <= '0;
      flag_update_count <= '0;
    end else begin
      if (load_en && branch_next) taken_count <= taken_count + 32'd1;
      if (flag_update) flag_update_count <= flag_update_count + 32'd1;
    end
  end
`endif

endmodule
